// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   MEM stage plus MEM/WB pipeline register of the 5-stage RV32 core.
//   Takes the EX/MEM register outputs and runs one data-memory access per
//   load/store over a req/ready handshake. stall_o stays high while the access
//   is pending. The block registers the write-back bundle (ctrl, ALU result,
//   load data, rd) for the WB mux and the forwarding unit.
//
//   Optional feature macro: MEM_STAGE_TIMEOUT_EN
//     defined   -> an access aborts after TIMEOUT_CYC not-ready ACCESS cycles and
//                  sets the sticky timeout_o flag
//     undefined -> ACCESS waits indefinitely and timeout_o is tied to 0
//
// Ports
//   clk_i, rst_i                  clock (rising edge), synchronous active-low reset
//   RegWrite_i, MemToReg_i,
//   MemRead_i, MemWrite_i         EX/MEM control bits
//   ALUresult_i, Readdata2_i      EX/MEM ALU result / address and store data
//   INS_11_7_i                    EX/MEM destination register (rd)
//   dmem_req_o, dmem_we_o,
//   dmem_addr_o, dmem_wdata_o     data-memory request, driven from the holding regs
//   dmem_rdata_i, dmem_ready_i    data-memory response
//   stall_o                       combinational freeze request to the hazard unit
//   RegWrite_o, MemToReg_o,
//   ALUresult_o, MemData_o,
//   RdAddr_o                      MEM/WB register outputs
//   timeout_o                     sticky access-abort flag
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALUresult_i,
    input  logic [DATA_W-1:0] Readdata2_i,
    input  logic [REG_W-1:0]  INS_11_7_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_ready_i,
    output logic              stall_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic [DATA_W-1:0] ALUresult_o,
    output logic [DATA_W-1:0] MemData_o,
    output logic [REG_W-1:0]  RdAddr_o,
    output logic              timeout_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              state_r;
    logic                req_r;
    logic                we_r;
    logic [DATA_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                hold_rw_r;
    logic                hold_mtr_r;
    logic [REG_W-1:0]    hold_rd_r;

    logic                mem_op_s;
    logic                abort_s;
    logic                stall_s;

    assign mem_op_s = MemRead_i | MemWrite_i;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]    cnt_r;
    logic                timeout_r;

    // Abort fires in the not-ready cycle that brings the wait count up to TIMEOUT_CYC.
    always_comb begin
        abort_s = 1'b0;
        if ((state_r == ST_ACCESS) && !dmem_ready_i && (cnt_r == CNT_W'(TIMEOUT_CYC - 1))) begin
            abort_s = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
    end

    // Wait counter (cleared on entry to ACCESS) and sticky abort flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && mem_op_s) begin
                cnt_r <= '0;
            end else if ((state_r == ST_ACCESS) && !dmem_ready_i) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (abort_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign timeout_o = timeout_r;
`else
    // The abort length only matters when the timeout counter is built.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign abort_s   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Stall upstream while an access is being launched or is still waiting.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    stall_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (dmem_ready_i || abort_s) begin
                    stall_s = 1'b0;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: stall_s = 1'b0;
        endcase
    end

    assign stall_o = stall_s;

    // MEM FSM: holding registers, request flag and MEM/WB register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            hold_rw_r   <= 1'b0;
            hold_mtr_r  <= 1'b0;
            hold_rd_r   <= '0;
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            ALUresult_o <= '0;
            MemData_o   <= '0;
            RdAddr_o    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s) begin
                        // A read+write combination is treated as a store.
                        state_r    <= ST_ACCESS;
                        req_r      <= 1'b1;
                        we_r       <= MemWrite_i;
                        addr_r     <= ALUresult_i;
                        wdata_r    <= Readdata2_i;
                        hold_rw_r  <= RegWrite_i;
                        hold_mtr_r <= MemToReg_i;
                        hold_rd_r  <= INS_11_7_i;
                        RegWrite_o <= 1'b0;
                        MemToReg_o <= 1'b0;
                    end else begin
                        RegWrite_o  <= RegWrite_i;
                        MemToReg_o  <= MemToReg_i;
                        ALUresult_o <= ALUresult_i;
                        RdAddr_o    <= INS_11_7_i;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ready_i) begin
                        state_r     <= ST_IDLE;
                        req_r       <= 1'b0;
                        RegWrite_o  <= hold_rw_r;
                        MemToReg_o  <= hold_mtr_r;
                        ALUresult_o <= addr_r;
                        RdAddr_o    <= hold_rd_r;
                        if (!we_r) begin
                            MemData_o <= dmem_rdata_i;
                        end else begin
                            MemData_o <= MemData_o;
                        end
                    end else if (abort_s) begin
                        // Aborted instruction is discarded: bubble into MEM/WB.
                        state_r    <= ST_IDLE;
                        req_r      <= 1'b0;
                        RegWrite_o <= 1'b0;
                        MemToReg_o <= 1'b0;
                    end else begin
                        RegWrite_o <= 1'b0;
                        MemToReg_o <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    req_r      <= 1'b0;
                    RegWrite_o <= 1'b0;
                    MemToReg_o <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req_o   = req_r;
    assign dmem_we_o    = we_r;
    assign dmem_addr_o  = addr_r;
    assign dmem_wdata_o = wdata_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//   Drives whole instructions into mem_wb_stage the way a frozen pipeline would
//   (inputs held while the instruction occupies MEM) and plays the data memory
//   with a per-access latency chosen by the bench. The expected timeline of each
//   instruction (stall, request, MEM/WB contents) follows from its kind and that
//   latency alone.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_ON = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUresult_i, Readdata2_i;
    logic [4:0]  INS_11_7_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic        dmem_ready_i;
    logic        stall_o;
    logic        RegWrite_o, MemToReg_o;
    logic [31:0] ALUresult_o, MemData_o;
    logic [4:0]  RdAddr_o;
    logic        timeout_o;

    mem_wb_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYC(TMO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .RegWrite_i   (RegWrite_i),
        .MemToReg_i   (MemToReg_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .ALUresult_i  (ALUresult_i),
        .Readdata2_i  (Readdata2_i),
        .INS_11_7_i   (INS_11_7_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ready_i (dmem_ready_i),
        .stall_o      (stall_o),
        .RegWrite_o   (RegWrite_o),
        .MemToReg_o   (MemToReg_o),
        .ALUresult_o  (ALUresult_o),
        .MemData_o    (MemData_o),
        .RdAddr_o     (RdAddr_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected MEM/WB contents; alu/rd are only defined after a real write or reset.
    logic        exp_rw, exp_mtr, exp_to, wb_known;
    logic [31:0] exp_alu, exp_md;
    logic [4:0]  exp_rd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        check_val("RegWrite_o", {31'd0, RegWrite_o}, {31'd0, exp_rw});
        check_val("MemToReg_o", {31'd0, MemToReg_o}, {31'd0, exp_mtr});
        check_val("MemData_o", MemData_o, exp_md);
        check_val("timeout_o", {31'd0, timeout_o}, {31'd0, exp_to});
        if (wb_known) begin
            check_val("ALUresult_o", ALUresult_o, exp_alu);
            check_val("RdAddr_o", {27'd0, RdAddr_o}, {27'd0, exp_rd});
        end
    endtask

    task automatic drive_idle();
        RegWrite_i   = 1'b0; MemToReg_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        ALUresult_i  = 32'd0; Readdata2_i = 32'd0; INS_11_7_i = 5'd0;
        dmem_ready_i = 1'b0; dmem_rdata_i = 32'd0;
    endtask

    // Called just after a reset edge: release reset, check the cleared state,
    // then let one all-zero cycle pass through.
    task automatic after_reset();
        exp_rw = 1'b0; exp_mtr = 1'b0; exp_to = 1'b0;
        exp_alu = 32'd0; exp_md = 32'd0; exp_rd = 5'd0; wb_known = 1'b1;
        @(negedge clk);
        rst_i = 1'b1;
        drive_idle();
        #1;
        check_regs();
        check_val("reset_req", {31'd0, dmem_req_o}, 32'd0);
        check_val("reset_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
    endtask

    // One instruction; lat = ACCESS cycle in which memory answers (memory ops only).
    task automatic run_instr(input logic rw, input logic mtr, input logic mr, input logic mw,
                             input logic [31:0] alu, input logic [31:0] rd2,
                             input logic [4:0] rd, input int lat);
        logic        memop;
        logic        abort;
        int          ncyc;
        logic [31:0] rdata;
        memop = mr | mw;
        abort = memop && TMO_ON && (lat > TMO);
        ncyc  = !memop ? 1 : (abort ? 1 + TMO : 1 + lat);
        rdata = $urandom;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check_regs();
            RegWrite_i = rw; MemToReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
            ALUresult_i = alu; Readdata2_i = rd2; INS_11_7_i = rd;
            // Random ready while no request is out must be ignored.
            dmem_ready_i = (c == 0) ? 1'($urandom_range(0, 1)) : (c == lat);
            dmem_rdata_i = (c == lat) ? rdata : $urandom;
            #1;
            check_val("stall_o", {31'd0, stall_o}, {31'd0, (c != ncyc - 1)});
            check_val("dmem_req_o", {31'd0, dmem_req_o}, {31'd0, (c >= 1)});
            if (c >= 1) begin
                check_val("dmem_addr_o", dmem_addr_o, alu);
                check_val("dmem_we_o", {31'd0, dmem_we_o}, {31'd0, mw});
                if (mw) begin
                    check_val("dmem_wdata_o", dmem_wdata_o, rd2);
                end
            end
            @(posedge clk);
            if (c == ncyc - 1) begin
                if (!memop || !abort) begin
                    exp_rw = rw; exp_mtr = mtr; exp_alu = alu; exp_rd = rd; wb_known = 1'b1;
                    if (memop && !mw) begin
                        exp_md = rdata;
                    end
                end else begin
                    exp_rw = 1'b0; exp_mtr = 1'b0; wb_known = 1'b0; exp_to = 1'b1;
                end
            end else begin
                exp_rw = 1'b0; exp_mtr = 1'b0; wb_known = 1'b0;
            end
        end
    endtask

    // Reset lands while a load is waiting in ACCESS with ready low.
    task automatic reset_mid_access();
        @(negedge clk);
        check_regs();
        RegWrite_i = 1'b1; MemToReg_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        ALUresult_i = 32'h0000_0100; Readdata2_i = 32'd0; INS_11_7_i = 5'd9;
        dmem_ready_i = 1'b0;
        @(posedge clk);
        exp_rw = 1'b0; exp_mtr = 1'b0; wb_known = 1'b0;
        @(negedge clk);
        check_regs();
        #1;
        check_val("rst_pre_req", {31'd0, dmem_req_o}, 32'd1);
        @(negedge clk);
        rst_i = 1'b0;
        drive_idle();
        @(posedge clk);
        after_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        int          kind;
        rst_i = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        after_reset();

        // R-type write-back with 1-cycle latency
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 0);
        // Load answered in the 3rd ACCESS cycle
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd7, 3);
        // Store answered immediately
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 5'd3, 1);
        // Back-to-back loads
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 5'd10, 1);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'd0, 5'd11, 1);
        // Read and write both set behaves as a store
        run_instr(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h1357_9BDF, 5'd12, 2);
        // Reset during a pending access, then a normal ALU op
        reset_mid_access();
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE, 32'd0, 5'd31, 0);
        // Long wait: aborts when the timeout is built, completes otherwise
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 5'd13, 6);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5555, 32'd0, 5'd14, 0);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0304, 32'd0, 5'd15, 2);

        // Random instruction mix with random memory latency
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom;
            d    = $urandom;
            case (kind)
                0, 1:    run_instr(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, a, d, 5'($urandom), 0);
                2:       run_instr(1'b1, 1'b1, 1'b1, 1'b0, a, d, 5'($urandom), $urandom_range(1, 6));
                default: run_instr(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, a, d, 5'($urandom),
                                   $urandom_range(1, 6));
            endcase
        end
        @(negedge clk);
        check_regs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
